// File: rtl/simon64_128_core.sv
// simon64_128_core: iterative SIMON 64/128 block cipher, one round per clock, key expanded once
// into a round-key register array. Define SIMON_DECRYPT_EN to add decryption (reverse key walk).
module simon64_128_core #(
   parameter int ROUNDS = 44
) (
   input  logic         clk_100MHz,
   input  logic         reset,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         key_ready,
   input  logic [63:0]  block_in,
   input  logic         start,
   input  logic         decrypt,
   output logic         busy,
   output logic         done,
   output logic [63:0]  block_out
);

   // state    | meaning
   // S_IDLE   | no valid key; waits for key_load, start ignored
   // S_EXPAND | writes one round key per cycle, k[4] .. k[ROUNDS-1]
   // S_READY  | key valid; start runs a block, key_load rekeys
   // S_RUN    | one cipher round per cycle
   // S_DONE   | registers the result and pulses done in the following cycle

   localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [61:0] Z3 =
      62'b11011011101011000110010111100000010010001010011100110100001111;
   localparam logic [CW-1:0] EXP_LAST = CW'(ROUNDS - 5);
   localparam logic [CW-1:0] RUN_LAST = CW'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXPAND,
      S_READY,
      S_RUN,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [31:0]   r_key [ROUNDS];
   logic [31:0]   r_x;
   logic [31:0]   r_y;
   logic [CW-1:0] r_idx;
   logic [CW-1:0] r_tmr;

   logic          w_key_cap;
   logic          w_run_go;
   logic [31:0]   w_k0;
   logic [31:0]   w_k1;
   logic [31:0]   w_k3;
   logic [31:0]   w_tmp;
   logic [5:0]    w_zidx;
   logic [31:0]   w_knew;
   logic [31:0]   w_rk;
   logic [31:0]   w_x_nxt;
   logic [31:0]   w_y_nxt;

`ifdef SIMON_DECRYPT_EN
   logic          r_dec;
`else
   logic          w_unused_decrypt;
   assign w_unused_decrypt = decrypt;
`endif

   function automatic logic [31:0] simon_f(input logic [31:0] v);
      return ({v[30:0], v[31]} & {v[23:0], v[31:24]}) ^ {v[29:0], v[31:30]};
   endfunction

   // start has priority over key_load in READY, so a simultaneous rekey is dropped entirely
   assign w_run_go  = start && (r_state == S_READY);
   assign w_key_cap = key_load && ((r_state == S_IDLE) || ((r_state == S_READY) && !start));

   assign w_k0   = r_key[r_idx];
   assign w_k1   = r_key[r_idx + CW'(1)];
   assign w_k3   = r_key[r_idx + CW'(3)];
   assign w_tmp  = {w_k3[2:0], w_k3[31:3]} ^ w_k1;
   assign w_zidx = 6'd61 - 6'(r_idx);
   assign w_knew = ~w_k0 ^ w_tmp ^ {w_tmp[0], w_tmp[31:1]} ^ {31'd0, Z3[w_zidx]} ^ 32'h3;

   assign w_rk = r_key[r_idx];

   always_comb begin
      w_x_nxt = r_y ^ simon_f(r_x) ^ w_rk;
      w_y_nxt = r_x;
`ifdef SIMON_DECRYPT_EN
      if (r_dec) begin
         w_x_nxt = r_y;
         w_y_nxt = r_x ^ simon_f(r_y) ^ w_rk;
      end
`endif
   end

   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (key_load) begin
               if (ROUNDS > 4) w_state_nxt = S_EXPAND;
               else            w_state_nxt = S_READY;
            end
         end
         S_EXPAND: begin
            if (r_tmr == '0) w_state_nxt = S_READY;
         end
         S_READY: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end else if (key_load) begin
               if (ROUNDS > 4) w_state_nxt = S_EXPAND;
               else            w_state_nxt = S_READY;
            end
         end
         S_RUN: begin
            if (r_tmr == '0) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_READY;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      key_ready = 1'b0;
      busy      = 1'b0;
      case (r_state)
         S_EXPAND: busy = 1'b1;
         S_READY:  key_ready = 1'b1;
         S_RUN: begin
            key_ready = 1'b1;
            busy      = 1'b1;
         end
         S_DONE: begin
            key_ready = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            key_ready = 1'b0;
            busy      = 1'b0;
         end
      endcase
   end

   // r_tmr counts remaining cycles of EXPAND/RUN down to a terminal zero; r_idx addresses the keys
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_x       <= '0;
         r_y       <= '0;
         r_idx     <= '0;
         r_tmr     <= '0;
         done      <= 1'b0;
         block_out <= '0;
`ifdef SIMON_DECRYPT_EN
         r_dec     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE, S_READY: begin
               if (w_run_go) begin
                  r_x   <= block_in[63:32];
                  r_y   <= block_in[31:0];
                  r_tmr <= RUN_LAST;
`ifdef SIMON_DECRYPT_EN
                  r_dec <= decrypt;
                  r_idx <= decrypt ? RUN_LAST : '0;
`else
                  r_idx <= '0;
`endif
               end else if (w_key_cap) begin
                  r_idx <= '0;
                  r_tmr <= EXP_LAST;
               end
            end
            S_EXPAND: begin
               if (r_tmr != '0) begin
                  r_tmr <= r_tmr - CW'(1);
                  r_idx <= r_idx + CW'(1);
               end
            end
            S_RUN: begin
               r_x <= w_x_nxt;
               r_y <= w_y_nxt;
               if (r_tmr != '0) begin
                  r_tmr <= r_tmr - CW'(1);
`ifdef SIMON_DECRYPT_EN
                  r_idx <= r_dec ? (r_idx - CW'(1)) : (r_idx + CW'(1));
`else
                  r_idx <= r_idx + CW'(1);
`endif
               end
            end
            S_DONE: begin
               block_out <= {r_x, r_y};
               done      <= 1'b1;
            end
            default: begin
               r_idx <= '0;
               r_tmr <= '0;
            end
         endcase
      end
   end

   // Key contents are don't-care after reset, so the array carries no reset
   always_ff @(posedge clk_100MHz) begin
      if (w_key_cap) begin
         r_key[0] <= key_in[31:0];
         r_key[1] <= key_in[63:32];
         r_key[2] <= key_in[95:64];
         r_key[3] <= key_in[127:96];
      end else if (r_state == S_EXPAND) begin
         r_key[r_idx + CW'(4)] <= w_knew;
      end
   end

endmodule

// File: tb/tb_simon64_128_core.sv
// Bench for simon64_128_core: randomized blocks and keys checked through a scoreboard against a
// plain-arithmetic SIMON 64/128 model; also covers timing, ignored inputs, resets and rekeying.
module tb_simon64_128_core;

   localparam int ROUNDS = 44;
   localparam logic [127:0] KEY1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
   localparam logic [63:0]  PT1  = 64'h656b696c_20646e75;
   localparam logic [63:0]  CT1  = 64'h44c8fc20_b9dfa07a;
`ifdef SIMON_DECRYPT_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   logic         clk_100MHz = 1'b0;
   logic         reset      = 1'b0;
   logic [127:0] key_in     = '0;
   logic         key_load   = 1'b0;
   logic         key_ready;
   logic [63:0]  block_in   = '0;
   logic         start      = 1'b0;
   logic         decrypt    = 1'b0;
   logic         busy;
   logic         done;
   logic [63:0]  block_out;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [63:0]  exp_q[$];
   logic [63:0]  last_out = '0;
   logic [127:0] cur_key  = '0;
   string        z3s = "11011011101011000110010111100000010010001010011100110100001111";

   simon64_128_core #(.ROUNDS(ROUNDS)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .key_in     (key_in),
      .key_load   (key_load),
      .key_ready  (key_ready),
      .block_in   (block_in),
      .start      (start),
      .decrypt    (decrypt),
      .busy       (busy),
      .done       (done),
      .block_out  (block_out)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   function automatic logic [31:0] ror(input logic [31:0] v, input int n);
      return (v >> n) | (v << (32 - n));
   endfunction

   function automatic logic [31:0] rol(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [31:0] fn(input logic [31:0] v);
      return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
   endfunction

   function automatic logic [63:0] model(input logic [127:0] key, input logic [63:0] blk,
                                         input bit dec);
      logic [31:0] k [ROUNDS];
      logic [31:0] x, y, t, tmp;
      for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
      for (int i = 0; i < ROUNDS - 4; i++) begin
         tmp = ror(k[i+3], 3) ^ k[i+1];
         k[i+4] = ~k[i] ^ tmp ^ ror(tmp, 1) ^ 32'h3 ^ ((z3s[i] == "1") ? 32'h1 : 32'h0);
      end
      x = blk[63:32];
      y = blk[31:0];
      if (!dec) begin
         for (int r = 0; r < ROUNDS; r++) begin
            t = x;
            x = y ^ fn(x) ^ k[r];
            y = t;
         end
      end else begin
         for (int r = ROUNDS - 1; r >= 0; r--) begin
            t = y;
            y = x ^ fn(y) ^ k[r];
            x = t;
         end
      end
      return {x, y};
   endfunction

   function automatic logic [63:0] expect_out(input logic [127:0] key, input logic [63:0] blk,
                                              input bit dec);
      return model(key, blk, dec & DEC_EN);
   endfunction

   function automatic void check(input string name, input logic [127:0] act,
                                 input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   always @(negedge clk_100MHz) begin
      logic [63:0] e;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: block_out=%0h, nothing expected", block_out);
         end else begin
            e = exp_q.pop_front();
            check("block_out", block_out, e);
         end
      end
   end

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_key_ready"}, key_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_block_out"}, block_out, 0);
   endtask

   task automatic try_start_ignored(input string tag);
      block_in = PT1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check({tag, "_busy"}, busy, 0);
      check({tag, "_key_ready"}, key_ready, 0);
   endtask

   task automatic load_key(input logic [127:0] key);
      int cnt;
      key_in = key;
      key_load = 1'b1;
      step();
      key_load = 1'b0;
      cur_key = key;
      check("busy_expand", busy, 1);
      check("key_ready_expand", key_ready, 0);
      cnt = 0;
      while (key_ready !== 1'b1 && cnt < 200) begin
         step();
         cnt++;
      end
      check("key_ready_latency", cnt, ROUNDS - 4);
      check("hold_expand", block_out, last_out);
   endtask

   task automatic run_block(input logic [63:0] blk, input bit dec, input logic [63:0] e,
                            input bit poke);
      int cnt;
      block_in = blk;
      decrypt = dec;
      start = 1'b1;
      exp_q.push_back(e);
      step();
      start = 1'b0;
      decrypt = 1'b0;
      key_load = 1'b0;
      check("busy_run", busy, 1);
      check("key_ready_run", key_ready, 1);
      cnt = 0;
      while (done !== 1'b1 && cnt < 200) begin
         start = poke && (cnt == 10);
         if (start) block_in = {$urandom, $urandom};
         key_load = poke && (cnt == 20);
         if (key_load) key_in = {$urandom, $urandom, $urandom, $urandom};
         step();
         cnt++;
         if (cnt == 20) check("hold_run", block_out, last_out);
         if (poke && cnt == 21) check("key_ready_poke", key_ready, 1);
      end
      start = 1'b0;
      key_load = 1'b0;
      check("done_latency", cnt, ROUNDS + 1);
      check("busy_at_done", busy, 0);
      last_out = e;
      step();
      check("done_pulse", done, 0);
      check("hold_after", block_out, e);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0]  blk;
      logic [127:0] k;
      bit           d;

      repeat (5) step();
      check_zero("reset");
      reset = 1'b1;
      step();
      try_start_ignored("idle_start");

      // known answer, with a stray start at r=10 and key_load at r=20 during RUN
      load_key(KEY1);
      run_block(PT1, 1'b0, CT1, 1'b1);
      repeat (5) step();
      check("hold_idle", block_out, CT1);

      // rekey to zero in READY
      load_key('0);
      run_block('0, 1'b0, expect_out('0, '0, 1'b0), 1'b0);

      // simultaneous start and key_load: start wins, key unchanged
      blk = {$urandom, $urandom};
      key_in = {$urandom, $urandom, $urandom, $urandom};
      key_load = 1'b1;
      run_block(blk, 1'b0, expect_out(cur_key, blk, 1'b0), 1'b0);
      run_block(PT1, 1'b0, expect_out(cur_key, PT1, 1'b0), 1'b0);

      for (int t = 0; t < 4; t++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         load_key(k);
         for (int b = 0; b < 2; b++) begin
            blk = {$urandom, $urandom};
            d = 1'($urandom_range(0, 1));
            run_block(blk, d, expect_out(cur_key, blk, d), 1'b0);
         end
      end

      load_key(KEY1);
      run_block(CT1, 1'b1, DEC_EN ? PT1 : expect_out(KEY1, CT1, 1'b0), 1'b0);

      // reset during EXPAND at i=20
      key_in = KEY1;
      key_load = 1'b1;
      step();
      key_load = 1'b0;
      repeat (20) step();
      reset = 1'b0;
      #1;
      check_zero("rst_expand");
      last_out = '0;
      step();
      step();
      reset = 1'b1;
      try_start_ignored("after_rst_expand");

      // reset during RUN at r=30
      load_key(KEY1);
      block_in = PT1;
      start = 1'b1;
      exp_q.push_back(CT1);
      step();
      start = 1'b0;
      repeat (30) step();
      reset = 1'b0;
      #1;
      check_zero("rst_run");
      exp_q.delete();
      last_out = '0;
      step();
      step();
      reset = 1'b1;
      try_start_ignored("after_rst_run");

      load_key(KEY1);
      run_block(PT1, 1'b0, CT1, 1'b0);

      repeat (5) step();
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
